// File: rtl/hififo_tpc_request.sv
// hififo_tpc_request: queues host page addresses and issues one request per page to the TPC FIFO stage
module hififo_tpc_request #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PAGE_WORDS = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pg_valid,
  input  logic [60:0] pg_addr,
  output logic        pg_ready,
  input  logic        abort,
  input  logic [15:0] irq_match,
  output logic        r_valid,
  output logic        r_abort,
  output logic [60:0] r_addr,
  output logic [18:0] r_count,
  input  logic        r_ready,
  output logic        irq,
  output logic [31:0] status
);
  localparam int OFS = $clog2(PAGE_WORDS);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
  state_t state;
  logic [60:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wptr, rptr, fill;
  logic [15:0] done_count;
  logic err, push, aligned;
  assign fill = wptr - rptr;
  assign pg_ready = fill != (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  assign push = pg_valid && pg_ready && !abort;
  assign aligned = pg_addr[OFS-1:0] == '0;
  assign r_count = 19'(PAGE_WORDS);
  assign status = {err, state != IDLE, 6'd0, 8'(fill), done_count};
  always_ff @(posedge clock)
    if (push && aligned) mem[wptr[DEPTH_LOG2-1:0]] <= pg_addr;
  // abort outranks everything, so a pop or completion in the abort cycle is lost
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      r_addr <= '0;
      irq <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      done_count <= '0;
      err <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      r_valid <= 1'b0;
      r_abort <= 1'b1;
      irq <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      done_count <= '0;
      err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      irq <= 1'b0;
      if (push) begin
        if (aligned) wptr <= wptr + 1'b1;
        else err <= 1'b1;
      end
      case (state)
        IDLE:
          if (fill != '0 && r_ready) begin
            state <= ISSUE;
            r_valid <= 1'b1;
            r_addr <= mem[rptr[DEPTH_LOG2-1:0]];
          end
        ISSUE: begin
          rptr <= rptr + 1'b1;
          state <= SETTLE;
        end
        SETTLE: state <= WAIT;
        WAIT:
          if (r_ready) begin
            done_count <= done_count + 16'd1;
            irq <= irq_match != 16'd0 && done_count + 16'd1 == irq_match;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hififo_tpc_request.sv
// tb_hififo_tpc_request: randomized and directed checks against a queue-level model of the page sequencer
module tb_hififo_tpc_request;
  logic clock = 0, reset_n = 0, pg_valid = 0, abort = 0, r_ready = 1;
  logic [60:0] pg_addr = 0;
  logic [15:0] irq_match = 0;
  logic pg_ready, r_valid, r_abort, irq;
  logic [60:0] r_addr;
  logic [18:0] r_count;
  logic [31:0] status;
  int n_cmp = 0, n_bad = 0;
  logic [60:0] q[$];
  bit pop_pend, v_prev, irq_prev, exp_rabort, m_err, hold;
  int rem = 0, busy = 512, issued = 0, irqs = 0;

  hififo_tpc_request dut (
    .clock(clock), .reset_n(reset_n), .pg_valid(pg_valid), .pg_addr(pg_addr),
    .pg_ready(pg_ready), .abort(abort), .irq_match(irq_match), .r_valid(r_valid),
    .r_abort(r_abort), .r_addr(r_addr), .r_count(r_count), .r_ready(r_ready),
    .irq(irq), .status(status)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: model sees the edge, then every output is compared
  task automatic tick();
    bit acc, ab;
    acc = pg_valid && !abort && q.size() < 16;
    ab = abort;
    @(posedge clock);
    #1;
    if (!reset_n || ab) begin
      q.delete();
      m_err = 0;
      issued = 0;
      irqs = 0;
      rem = 0;
      pop_pend = 0;
    end else begin
      if (pop_pend) void'(q.pop_front());
      pop_pend = 0;
      if (acc) begin
        if (pg_addr[8:0] != 0) m_err = 1;
        else q.push_back(pg_addr);
      end
      rem = v_prev ? busy : (rem > 0 ? rem - 1 : 0);
    end
    exp_rabort = reset_n && ab;
    r_ready = !hold && rem == 0;
    check("r_abort", r_abort, exp_rabort);
    check("fill", status[23:16], q.size());
    check("pg_ready", pg_ready, q.size() < 16);
    check("err", status[31], m_err);
    if (r_valid) begin
      check("r_valid_width", v_prev, 0);
      check("r_count", r_count, 512);
      if (q.size() == 0) check("r_addr_empty", q.size(), 1);
      else check("r_addr", r_addr, q[0]);
      pop_pend = 1;
      issued++;
    end
    if (irq) begin
      irqs++;
      check("irq_width", irq_prev, 0);
      check("irq_done", status[15:0], irq_match);
    end
    v_prev = r_valid;
    irq_prev = irq;
  endtask

  task automatic push(logic [60:0] a);
    pg_valid = 1;
    pg_addr = a;
    tick();
    pg_valid = 0;
  endtask

  task automatic pulse_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    pg_valid = 0;
    abort = 0;
    hold = 0;
    while ((q.size() != 0 || pop_pend || rem != 0) && n < 40000) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < 40000, 1);
    repeat (6) tick();
    check({tag, "_done"}, status[15:0], 16'(issued));
    check({tag, "_busy"}, status[30], 0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_r_valid", r_valid, 0);
    check("rst_r_abort", r_abort, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_r_count", r_count, 512);
    check("rst_irq", irq, 0);
    check("rst_status", status, 0);
    check("rst_pg_ready", pg_ready, 1);
    reset_n = 1;
    tick();

    busy = 512;
    push(61'h200);
    tick();
    check("latency", r_valid, 1);
    push(61'h400);
    push(61'h600);
    drain("t1");
    check("t1_pulses", issued, 3);

    busy = 2;
    hold = 1;
    r_ready = 0;
    for (int i = 0; i < 16; i++) push(61'(i + 1) << 9);
    check("t2_fill", status[23:16], 16);
    check("t2_full", pg_ready, 0);
    push(61'h11 << 9);
    check("t2_fill17", status[23:16], 16);
    hold = 0;
    r_ready = 1;
    n = 0;
    while (!r_valid && n < 50) begin
      tick();
      n++;
    end
    check("t2_issue_timeout", n < 50, 1);
    check("t2_ready_at_issue", pg_ready, 0);
    tick();
    check("t2_ready_after_pop", pg_ready, 1);
    drain("t2");

    push(61'h201);
    check("t3_err", status[31], 1);
    check("t3_fill", status[23:16], 0);
    pulse_abort();
    check("t3_err_clr", status[31], 0);
    check("t3_rabort", r_abort, 1);
    tick();
    check("t3_rabort_end", r_abort, 0);

    irq_match = 2;
    busy = 3;
    for (int i = 0; i < 3; i++) push(61'(i + 5) << 9);
    drain("t4");
    check("t4_irqs", irqs, 1);
    irq_match = 0;
    pulse_abort();
    for (int i = 0; i < 3; i++) push(61'(i + 9) << 9);
    drain("t4b");
    check("t4b_irqs", irqs, 0);

    busy = 1000;
    for (int i = 0; i < 6; i++) push(61'(i + 20) << 9);
    n = 0;
    while (issued < 1 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("t5_fill", status[23:16], 5);
    check("t5_busy", status[30], 1);
    pulse_abort();
    check("t5_rabort", r_abort, 1);
    check("t5_flush", status[23:16], 0);
    check("t5_done_clr", status[15:0], 0);
    repeat (600) tick();
    check("t5_no_issue", issued, 0);

    busy = 50;
    push(61'h800);
    n = 0;
    while (!r_valid && n < 50) begin
      tick();
      n++;
    end
    tick();
    #2 reset_n = 0;
    #1;
    check("t6_r_valid", r_valid, 0);
    check("t6_r_addr", r_addr, 0);
    check("t6_status", status, 0);
    check("t6_pg_ready", pg_ready, 1);
    check("t6_irq", irq, 0);
    repeat (2) tick();
    reset_n = 1;
    tick();

    irq_match = 16'($urandom_range(1, 6));
    for (int i = 0; i < 3000; i++) begin
      pg_valid = $urandom % 2;
      pg_addr = 61'({$urandom, $urandom});
      if ($urandom % 12 != 0) pg_addr[8:0] = 0;
      abort = ($urandom % 300) == 0;
      hold = ($urandom % 8) == 0;
      busy = $urandom_range(0, 12);
      tick();
    end
    abort = 0;
    drain("rand");
    check("rand_irqs", irqs, issued >= irq_match);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
